// File: rtl/hole_fill_pkg.sv
// Shared definitions for the streaming hole filler: pixel tags, window slot
// bookkeeping and the line-flush FSM states.
package hole_fill_pkg;

    localparam logic [1:0] TAG_VALID = 2'b00;
    localparam logic [1:0] TAG_MED   = 2'b10;
    localparam logic [1:0] TAG_LOW   = 2'b01;
    localparam logic [1:0] TAG_VOID  = 2'b11;

    // Per-slot bookkeeping; the disparity word lives in a parallel array
    // because its width is a module parameter.
    typedef struct packed {
        logic [1:0] tag;
        logic       is_real;
        logic       sol;
        logic       eol;
    } slot_meta_t;

    localparam slot_meta_t SLOT_VOID = '{tag: TAG_VOID, is_real: 1'b0, sol: 1'b0, eol: 1'b0};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hole_sort_net.sv
// Combinational odd-even transposition sorter: descending, counting entries
// first, non-counting entries forced to zero and placed last, ties stable.
module hole_sort_net #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int CNT_W = 3
) (
    input  logic [N-1:0][W-1:0] val,
    input  logic [N-1:0]        ok,
    output logic [N-1:0][W-1:0] sorted,
    output logic [CNT_W-1:0]    cnt
);

    logic [N-1:0][W:0] key;
    logic [W:0]        tmp;

    always_comb begin
        tmp = '0;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            key[i] = ok[i] ? {1'b1, val[i]} : '0;
            cnt    = cnt + CNT_W'(ok[i]);
        end
        // Strict compare keeps equal keys in arrival order.
        for (int r = 0; r < N; r++) begin
            for (int i = r % 2; i < N - 1; i += 2) begin
                if (key[i+1] > key[i]) begin
                    tmp      = key[i];
                    key[i]   = key[i+1];
                    key[i+1] = tmp;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            sorted[i] = key[i][W-1:0];
        end
    end

endmodule

// File: rtl/hole_filling_stream.sv
// Streaming hole filler: builds a TAPS-wide window per line, flushes line ends,
// fills holes from the median / lower median of valid neighbours, counts per frame.
module hole_filling_stream
    import hole_fill_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int TAPS      = 5,
    parameter int MIN_VALID = 1,
    parameter int STAT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH+1:0]    in_data,
    input  logic                in_sof,
    input  logic                in_sol,
    input  logic                in_eol,
    output logic                out_valid,
    output logic [WIDTH+1:0]    out_data,
    output logic                out_sol,
    output logic                out_eol,
    output logic [STAT_W-1:0]   stat_filled,
    output logic [STAT_W-1:0]   stat_unfilled
);

    localparam int HALF  = (TAPS - 1) / 2;
    localparam int N     = TAPS - 1;
    localparam int CNT_W = $clog2(TAPS);
    localparam int FL_W  = $clog2(HALF + 1);

    state_t            state_q;
    logic [FL_W-1:0]   flush_cnt_q;
    slot_meta_t        meta_q [TAPS];
    logic [WIDTH-1:0]  data_q [TAPS];
    logic              upd_q;

    logic accept, shift;
    assign accept = in_valid & in_ready;
    assign shift  = accept | (state_q == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            in_ready    <= 1'b1;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && in_eol) begin
                        state_q     <= ST_FLUSH;
                        in_ready    <= 1'b0;
                        flush_cnt_q <= FL_W'(HALF - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q  <= ST_RUN;
                        in_ready <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Slot 0 is the newest pixel; a start-of-line voids everything older.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                meta_q[i] <= SLOT_VOID;
                data_q[i] <= '0;
            end
        end else begin
            upd_q <= shift;
            if (shift) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    if (accept && in_sol) begin
                        meta_q[i] <= SLOT_VOID;
                        data_q[i] <= '0;
                    end else begin
                        meta_q[i] <= meta_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
                if (accept) begin
                    meta_q[0] <= '{tag: in_data[WIDTH+1:WIDTH], is_real: 1'b1,
                                   sol: in_sol, eol: in_eol};
                    data_q[0] <= in_data[WIDTH-1:0];
                end else begin
                    meta_q[0] <= SLOT_VOID;
                    data_q[0] <= '0;
                end
            end
        end
    end

    logic [N-1:0][WIDTH-1:0] nb_val;
    logic [N-1:0]            nb_ok;
    logic [N-1:0][WIDTH-1:0] nb_sorted;
    logic [CNT_W-1:0]        nb_cnt;

    for (genvar g = 0; g < N; g++) begin : g_nb
        localparam int SI = (g < HALF) ? g : g + 1;
        assign nb_val[g] = data_q[SI];
        assign nb_ok[g]  = meta_q[SI].is_real && (meta_q[SI].tag == TAG_VALID);
    end

    hole_sort_net #(.N(N), .W(WIDTH), .CNT_W(CNT_W)) u_sort (
        .val    (nb_val),
        .ok     (nb_ok),
        .sorted (nb_sorted),
        .cnt    (nb_cnt)
    );

    logic                    s1_valid;
    logic [N-1:0][WIDTH-1:0] s1_sorted;
    logic [CNT_W-1:0]        s1_cnt;
    logic [1:0]              s1_tag;
    logic [WIDTH-1:0]        s1_data;
    logic                    s1_sol, s1_eol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sorted <= '0;
            s1_cnt    <= '0;
            s1_tag    <= TAG_VOID;
            s1_data   <= '0;
            s1_sol    <= 1'b0;
            s1_eol    <= 1'b0;
        end else begin
            s1_valid  <= upd_q & meta_q[HALF].is_real;
            s1_sorted <= nb_sorted;
            s1_cnt    <= nb_cnt;
            s1_tag    <= meta_q[HALF].tag;
            s1_data   <= data_q[HALF];
            s1_sol    <= meta_q[HALF].sol;
            s1_eol    <= meta_q[HALF].eol;
        end
    end

    logic [CNT_W-1:0] med_idx, low_idx;
    logic [WIDTH-1:0] med_val, low_val;
    logic [WIDTH+1:0] res_data;
    logic             res_fill, res_unfill;

    assign med_idx = (s1_cnt - CNT_W'(1)) >> 1;
    assign low_idx = s1_cnt >> 1;

    always_comb begin
        med_val    = '0;
        low_val    = '0;
        res_data   = {TAG_VOID, {WIDTH{1'b0}}};
        res_fill   = 1'b0;
        res_unfill = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (CNT_W'(j) == med_idx) med_val = s1_sorted[j];
            if (CNT_W'(j) == low_idx) low_val = s1_sorted[j];
        end
        case (s1_tag)
            TAG_VALID: res_data = {TAG_VALID, s1_data};
            TAG_MED, TAG_LOW: begin
                if (s1_cnt >= CNT_W'(MIN_VALID)) begin
                    res_data = {TAG_VALID, (s1_tag == TAG_MED) ? med_val : low_val};
                    res_fill = 1'b1;
                end else begin
                    res_unfill = 1'b1;
                end
            end
            default: res_data = {TAG_VOID, {WIDTH{1'b0}}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sol       <= 1'b0;
            out_eol       <= 1'b0;
            stat_filled   <= '0;
            stat_unfilled <= '0;
        end else begin
            out_valid <= s1_valid;
            out_sol   <= s1_valid & s1_sol;
            out_eol   <= s1_valid & s1_eol;
            if (s1_valid) out_data <= res_data;
            // Frame start wins over a stale count from the previous frame.
            if (accept && in_sof) begin
                stat_filled   <= '0;
                stat_unfilled <= '0;
            end else if (s1_valid) begin
                if (res_fill && stat_filled != '1)
                    stat_filled <= stat_filled + STAT_W'(1);
                if (res_unfill && stat_unfilled != '1)
                    stat_unfilled <= stat_unfilled + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hole_filling_stream.sv
// Directed bench for hole_filling_stream (WIDTH=16, TAPS=5, MIN_VALID=1).
module tb_hole_filling_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic        in_sof = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_sol, out_eol;
    logic [15:0] stat_filled, stat_unfilled;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [17:0] q_data[$];
    logic        q_sol[$];
    logic        q_eol[$];
    int          q_cyc[$];

    hole_filling_stream #(.WIDTH(16), .TAPS(5), .MIN_VALID(1), .STAT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sof        (in_sof),
        .in_sol        (in_sol),
        .in_eol        (in_eol),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_sol       (out_sol),
        .out_eol       (out_eol),
        .stat_filled   (stat_filled),
        .stat_unfilled (stat_unfilled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            q_data.push_back(out_data);
            q_sol.push_back(out_sol);
            q_eol.push_back(out_eol);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sol.delete();
        q_eol.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_eol   = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] tag, input logic [15:0] d,
                        input logic sol, input logic eol, input logic sof,
                        output int acc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = {tag, d};
        in_sol   = sol;
        in_eol   = eol;
        in_sof   = sof;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) chk("send_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_eol   = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        int a;
        int acc[6];
        logic [15:0] five[5];

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sol", 64'(out_sol), 64'd0);
        chk("rst_stat_filled", 64'(stat_filled), 64'd0);
        chk("rst_stat_unfilled", 64'(stat_unfilled), 64'd0);

        // 1: all-valid line 1..8
        clear_q();
        for (int i = 1; i <= 8; i++)
            send(2'b00, 16'(i), i == 1, i == 8, i == 1, a);
        chk("t1_ready_flush0", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("t1_ready_flush1", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("t1_ready_back", 64'(in_ready), 64'd1);
        idle(6);
        chk("t1_count", 64'(q_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_data", 64'(q_data[i]), 64'(i + 1));
            chk("t1_sol", 64'(q_sol[i]), 64'(i == 0));
            chk("t1_eol", 64'(q_eol[i]), 64'(i == 7));
        end

        // 2: median / lower median with four neighbours
        five = '{16'd10, 16'd20, 16'h0999, 16'd30, 16'd40};
        clear_q();
        for (int i = 0; i < 5; i++)
            send(i == 2 ? 2'b10 : 2'b00, five[i], i == 0, i == 4, i == 0, a);
        idle(6);
        chk("t2_med_count", 64'(q_data.size()), 64'd5);
        chk("t2_med_first", 64'(q_data[0]), 64'd10);
        chk("t2_med_centre", 64'(q_data[2]), {46'd0, 2'b00, 16'd30});
        chk("t2_med_last", 64'(q_data[4]), 64'd40);
        clear_q();
        for (int i = 0; i < 5; i++)
            send(i == 2 ? 2'b01 : 2'b00, five[i], i == 0, i == 4, 1'b0, a);
        idle(6);
        chk("t2_low_centre", 64'(q_data[2]), {46'd0, 2'b00, 16'd20});
        chk("t2_stat_filled", 64'(stat_filled), 64'd2);
        chk("t2_stat_unfilled", 64'(stat_unfilled), 64'd0);

        // 3: 3-pixel line, hole completed by a flush cycle
        clear_q();
        send(2'b00, 16'd5, 1'b1, 1'b0, 1'b0, a);
        send(2'b10, 16'h0abc, 1'b0, 1'b0, 1'b0, a);
        send(2'b00, 16'd7, 1'b0, 1'b1, 1'b0, a);
        idle(6);
        chk("t3_med_count", 64'(q_data.size()), 64'd3);
        chk("t3_med_centre", 64'(q_data[1]), {46'd0, 2'b00, 16'd7});
        chk("t3_med_lat", 64'(q_cyc[1]), 64'(a + 3));
        clear_q();
        send(2'b00, 16'd5, 1'b1, 1'b0, 1'b0, a);
        send(2'b01, 16'h0abc, 1'b0, 1'b0, 1'b0, a);
        send(2'b00, 16'd7, 1'b0, 1'b1, 1'b0, a);
        idle(6);
        chk("t3_low_centre", 64'(q_data[1]), {46'd0, 2'b00, 16'd5});
        chk("t3_low_eol_pix", 64'(q_data[2]), 64'd7);
        chk("t3_stat_filled", 64'(stat_filled), 64'd4);

        // 4: all holes, then frame restart
        clear_q();
        for (int i = 0; i < 5; i++)
            send(2'b10, 16'(100 + i), i == 0, i == 4, i == 0, a);
        idle(6);
        chk("t4_count", 64'(q_data.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("t4_void", 64'(q_data[i]), {46'd0, 2'b11, 16'd0});
        chk("t4_unfilled", 64'(stat_unfilled), 64'd5);
        chk("t4_filled_cleared", 64'(stat_filled), 64'd0);
        clear_q();
        send(2'b11, 16'h1234, 1'b1, 1'b0, 1'b1, a);
        chk("t4_sof_clear", 64'(stat_unfilled), 64'd0);
        send(2'b10, 16'h0055, 1'b0, 1'b0, 1'b0, a);
        send(2'b11, 16'h4321, 1'b0, 1'b1, 1'b0, a);
        idle(6);
        chk("t4_recount", 64'(stat_unfilled), 64'd1);
        chk("t4_hole_out", 64'(q_data[1]), {46'd0, 2'b11, 16'd0});
        chk("t4_void_out", 64'(q_data[0]), {46'd0, 2'b11, 16'd0});

        // 5: valid toggling 1-0-1 across a 6-pixel line
        clear_q();
        for (int i = 0; i < 6; i++) begin
            send(2'b00, 16'(11 + i), i == 0, i == 5, 1'b0, acc[i]);
            idle(1);
        end
        idle(6);
        chk("t5_count", 64'(q_data.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t5_data", 64'(q_data[i]), 64'(11 + i));
            chk("t5_sol", 64'(q_sol[i]), 64'(i == 0));
            chk("t5_eol", 64'(q_eol[i]), 64'(i == 5));
        end
        for (int i = 0; i < 4; i++)
            chk("t5_lat", 64'(q_cyc[i]), 64'(acc[i+2] + 2));
        chk("t5_lat_fl1", 64'(q_cyc[4]), 64'(acc[5] + 3));
        chk("t5_lat_fl2", 64'(q_cyc[5]), 64'(acc[5] + 4));

        // length-1 line
        clear_q();
        send(2'b10, 16'h0077, 1'b1, 1'b1, 1'b0, a);
        idle(6);
        chk("t5_len1_count", 64'(q_data.size()), 64'd1);
        chk("t5_len1_data", 64'(q_data[0]), {46'd0, 2'b11, 16'd0});
        chk("t5_len1_sol", 64'(q_sol[0]), 64'd1);
        chk("t5_len1_eol", 64'(q_eol[0]), 64'd1);
        chk("t5_len1_stat", 64'(stat_unfilled), 64'd2);

        // 6: reset during flush
        for (int i = 1; i <= 5; i++)
            send(2'b00, 16'(i), i == 1, i == 5, 1'b0, a);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_stat_unfilled", 64'(stat_unfilled), 64'd0);
        chk("t6_stat_filled", 64'(stat_filled), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        clear_q();
        idle(6);
        chk("t6_discarded", 64'(q_data.size()), 64'd0);
        for (int i = 0; i < 5; i++)
            send(i == 2 ? 2'b10 : 2'b00, five[i], i == 0, i == 4, i == 0, a);
        idle(6);
        chk("t6_count", 64'(q_data.size()), 64'd5);
        chk("t6_centre", 64'(q_data[2]), {46'd0, 2'b00, 16'd30});
        chk("t6_first", 64'(q_data[0]), 64'd10);
        chk("t6_filled", 64'(stat_filled), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
